rdata_buf_s: RTL and testbench

- Per-slave read-response buffer between one slave's R channel and the 4-slave read-data mux input (rid/rdata/rlast/rresp/rvalid/rready).
- Decouples slave R-beat production from mux arbitration stalls.
- First-word-fall-through FIFO of R beats, plus a count of complete bursts held.
- One instance per slave; the downstream "_m" side connects to one slave input of the mux.

---
 rtl/rdata_buf_s.sv | 106 ++++++++++
 tb/tb_rdata_buf_s.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rdata_buf_s.sv
// Per-slave R-channel buffer: first-word-fall-through FIFO of R beats that also counts complete bursts held.
// Optional store-and-forward gating is compiled in with RDATA_BUF_STORE_FWD_EN.
module rdata_buf_s #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [3:0]        rid_s,
  input  logic [31:0]       rdata_s,
  input  logic              rlast_s,
  input  logic [1:0]        rresp_s,
  input  logic              rvalid_s,
  output logic              rready_s,
  output logic [3:0]        rid_m,
  output logic [31:0]       rdata_m,
  output logic              rlast_m,
  output logic [1:0]        rresp_m,
  output logic              rvalid_m,
  input  logic              rready_m,
  output logic [ADDR_W:0]   level,
  output logic [ADDR_W:0]   bursts
);

  // Handshakes: a beat moves on a side only at a rising edge where that side's
  // valid and ready are both high; valid never waits on ready, and once rvalid_m
  // is high it and the head fields hold until the beat is taken.

  localparam int ENTRY_W = 4 + 32 + 1 + 2;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] head;

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] bursts_q, bursts_d;

  logic full, empty, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  // Full when the pointers sit on the same slot but are one wrap apart.
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign rready_s = areset & ~full;

  assign head = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign {rid_m, rdata_m, rlast_m, rresp_m} = head;

  assign push = rvalid_s & rready_s;
  assign pop  = rvalid_m & rready_m;

  assign level  = wr_ptr_q - rd_ptr_q;
  assign bursts = bursts_q;

`ifdef RDATA_BUF_STORE_FWD_EN
  // Once a burst has started draining, keep it flowing until its last beat.
  logic head_in_burst_q, head_in_burst_d;

  always_comb begin
    head_in_burst_d = head_in_burst_q;
    if (pop) head_in_burst_d = ~rlast_m;
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) head_in_burst_q <= 1'b0;
    else         head_in_burst_q <= head_in_burst_d;
  end

  // The full override lets bursts longer than the buffer drain instead of deadlocking.
  assign rvalid_m = ~empty & ((bursts_q != '0) | full | head_in_burst_q);
`else
  assign rvalid_m = ~empty;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    bursts_d = bursts_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push & rlast_s, pop & rlast_m})
      2'b10:   bursts_d = bursts_q + 1'b1;
      2'b01:   bursts_d = bursts_q - 1'b1;
      default: bursts_d = bursts_q;
    endcase
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      bursts_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      bursts_q <= bursts_d;
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {rid_s, rdata_s, rlast_s, rresp_s};
  end

endmodule

// File: tb/tb_rdata_buf_s.sv
// Directed bench for rdata_buf_s: reset, burst ordering, full/back-pressure, streaming wrap,
// mid-burst reset, and (with RDATA_BUF_STORE_FWD_EN) store-and-forward gating.
module tb_rdata_buf_s;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic [3:0]  rid_s = '0;
  logic [31:0] rdata_s = '0;
  logic        rlast_s = 1'b0;
  logic [1:0]  rresp_s = '0;
  logic        rvalid_s = 1'b0;
  logic        rready_s;
  logic [3:0]  rid_m;
  logic [31:0] rdata_m;
  logic        rlast_m;
  logic [1:0]  rresp_m;
  logic        rvalid_m;
  logic        rready_m = 1'b0;
  logic [3:0]  level;
  logic [3:0]  bursts;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  rdata_buf_s #(.DEPTH(8), .ADDR_W(3)) dut (
    .aclk(aclk), .areset(areset),
    .rid_s(rid_s), .rdata_s(rdata_s), .rlast_s(rlast_s), .rresp_s(rresp_s),
    .rvalid_s(rvalid_s), .rready_s(rready_s),
    .rid_m(rid_m), .rdata_m(rdata_m), .rlast_m(rlast_m), .rresp_m(rresp_m),
    .rvalid_m(rvalid_m), .rready_m(rready_m),
    .level(level), .bursts(bursts)
  );

  always #5 aclk = ~aclk;

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_beat(input logic [3:0] id, input logic [31:0] d, input logic last);
    rvalid_s = 1'b1;
    rid_s    = id;
    rdata_s  = d;
    rlast_s  = last;
    rresp_s  = 2'b00;
  endtask

  task automatic test_reset;
    areset = 1'b0;
    repeat (3) tick();
    n_checks++; if (rready_s !== 1'b0) $display("FAIL reset_rready_s got %b want 0", rready_s); else n_pass++;
    n_checks++; if (rvalid_m !== 1'b0) $display("FAIL reset_rvalid_m got %b want 0", rvalid_m); else n_pass++;
    n_checks++; if (level !== 4'd0) $display("FAIL reset_level got %0d want 0", level); else n_pass++;
    n_checks++; if (bursts !== 4'd0) $display("FAIL reset_bursts got %0d want 0", bursts); else n_pass++;
    areset = 1'b1;
    #1;
    n_checks++; if (rready_s !== 1'b1) $display("FAIL release_rready_s got %b want 1", rready_s); else n_pass++;
    tick();
    n_checks++; if (rvalid_m !== 1'b0) $display("FAIL idle_rvalid_m got %b want 0", rvalid_m); else n_pass++;
  endtask

  task automatic test_burst4;
    rready_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(4'b0110, 32'h11 * (i + 1), i == 3);
      tick();
    end
    rvalid_s = 1'b0;
    n_checks++; if (level !== 4'd4) $display("FAIL b4_level got %0d want 4", level); else n_pass++;
    n_checks++; if (bursts !== 4'd1) $display("FAIL b4_bursts got %0d want 1", bursts); else n_pass++;
    rready_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (rvalid_m !== 1'b1) $display("FAIL b4_rvalid[%0d] got %b want 1", i, rvalid_m); else n_pass++;
      n_checks++; if (rid_m !== 4'b0110) $display("FAIL b4_rid[%0d] got %h want 6", i, rid_m); else n_pass++;
      n_checks++; if (rdata_m !== 32'h11 * (i + 1)) $display("FAIL b4_rdata[%0d] got %h want %h", i, rdata_m, 32'h11 * (i + 1)); else n_pass++;
      n_checks++; if (rlast_m !== (i == 3)) $display("FAIL b4_rlast[%0d] got %b want %b", i, rlast_m, i == 3); else n_pass++;
      tick();
    end
    rready_m = 1'b0;
    n_checks++; if (level !== 4'd0) $display("FAIL b4_end_level got %0d want 0", level); else n_pass++;
    n_checks++; if (bursts !== 4'd0) $display("FAIL b4_end_bursts got %0d want 0", bursts); else n_pass++;
    n_checks++; if (rvalid_m !== 1'b0) $display("FAIL b4_end_rvalid got %b want 0", rvalid_m); else n_pass++;
  endtask

  task automatic test_fill;
    rready_m = 1'b0;
    exp_q = {};
    for (int i = 0; i < 8; i++) begin
      drive_beat(4'b1000, 32'h100 + i, i == 7);
      exp_q.push_back(32'h100 + i);
      tick();
    end
    drive_beat(4'b1000, 32'hABC, 1'b0);
    #1;
    n_checks++; if (rready_s !== 1'b0) $display("FAIL fill_rready_s got %b want 0", rready_s); else n_pass++;
    n_checks++; if (level !== 4'd8) $display("FAIL fill_level got %0d want 8", level); else n_pass++;
    n_checks++; if (bursts !== 4'd1) $display("FAIL fill_bursts got %0d want 1", bursts); else n_pass++;
    rready_m = 1'b1;
    tick();
    rready_m = 1'b0;
    void'(exp_q.pop_front());
    n_checks++; if (level !== 4'd7) $display("FAIL fill_pop_level got %0d want 7", level); else n_pass++;
    n_checks++; if (rready_s !== 1'b1) $display("FAIL fill_pop_rready_s got %b want 1", rready_s); else n_pass++;
    tick();
    exp_q.push_back(32'hABC);
    rvalid_s = 1'b0;
    n_checks++; if (level !== 4'd8) $display("FAIL fill_refill_level got %0d want 8", level); else n_pass++;
    rready_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (rdata_m !== exp_q[0]) $display("FAIL fill_drain[%0d] got %h want %h", i, rdata_m, exp_q[0]); else n_pass++;
      void'(exp_q.pop_front());
      tick();
    end
    rready_m = 1'b0;
    n_checks++; if (level !== 4'd0 || bursts !== 4'd0) $display("FAIL fill_end got level %0d bursts %0d want 0 0", level, bursts); else n_pass++;
  endtask

  task automatic test_stream;
    exp_q = {};
    rready_m = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive_beat(4'b0100, 32'h200 + k, ((k + 1) % 5) == 0);
      #1;
      n_checks++; if (rready_s !== 1'b1) $display("FAIL stream_rready_s[%0d] got %b want 1", k, rready_s); else n_pass++;
      if (k > 0) begin
        n_checks++; if (rvalid_m !== 1'b1 || rdata_m !== exp_q[0]) $display("FAIL stream_head[%0d] got v%b %h want v1 %h", k, rvalid_m, rdata_m, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
      end
      exp_q.push_back(32'h200 + k);
      tick();
      n_checks++; if (level !== 4'd1) $display("FAIL stream_level[%0d] got %0d want 1", k, level); else n_pass++;
      n_checks++; if (bursts > 4'd1) $display("FAIL stream_bursts[%0d] got %0d want <=1", k, bursts); else n_pass++;
    end
    rvalid_s = 1'b0;
    n_checks++; if (rdata_m !== 32'h213 || rlast_m !== 1'b1) $display("FAIL stream_last got %h l%b want 213 l1", rdata_m, rlast_m); else n_pass++;
    tick();
    rready_m = 1'b0;
    n_checks++; if (level !== 4'd0 || bursts !== 4'd0) $display("FAIL stream_end got level %0d bursts %0d want 0 0", level, bursts); else n_pass++;
  endtask

  task automatic test_reset_mid;
    rready_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(4'b1100, 32'hDEAD_0000 + i, 1'b0);
      tick();
    end
    rvalid_s = 1'b0;
    n_checks++; if (level !== 4'd3 || bursts !== 4'd0) $display("FAIL mid_pre got level %0d bursts %0d want 3 0", level, bursts); else n_pass++;
    #2;
    areset = 1'b0;
    #1;
    n_checks++; if (rvalid_m !== 1'b0) $display("FAIL mid_rvalid got %b want 0", rvalid_m); else n_pass++;
    n_checks++; if (level !== 4'd0) $display("FAIL mid_level got %0d want 0", level); else n_pass++;
    n_checks++; if (rready_s !== 1'b0) $display("FAIL mid_rready_s got %b want 0", rready_s); else n_pass++;
    tick();
    areset = 1'b1;
    drive_beat(4'b0001, 32'h301, 1'b0);
    tick();
    drive_beat(4'b0001, 32'h302, 1'b1);
    tick();
    rvalid_s = 1'b0;
    n_checks++; if (level !== 4'd2 || bursts !== 4'd1) $display("FAIL mid_new got level %0d bursts %0d want 2 1", level, bursts); else n_pass++;
    rready_m = 1'b1;
    n_checks++; if (rdata_m !== 32'h301 || rid_m !== 4'b0001) $display("FAIL mid_head0 got %h id %h want 301 id 1", rdata_m, rid_m); else n_pass++;
    tick();
    n_checks++; if (rdata_m !== 32'h302 || rlast_m !== 1'b1) $display("FAIL mid_head1 got %h l%b want 302 l1", rdata_m, rlast_m); else n_pass++;
    tick();
    rready_m = 1'b0;
    n_checks++; if (rvalid_m !== 1'b0 || level !== 4'd0) $display("FAIL mid_end got v%b level %0d want v0 0", rvalid_m, level); else n_pass++;
  endtask

`ifdef RDATA_BUF_STORE_FWD_EN
  task automatic test_store_fwd;
    int idx;
    int cyc;
    rready_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_beat(4'b0010, 32'h400 + i, 1'b0);
      tick();
      n_checks++; if (rvalid_m !== 1'b0) $display("FAIL sf_gate[%0d] got %b want 0", i, rvalid_m); else n_pass++;
    end
    drive_beat(4'b0010, 32'h403, 1'b1);
    tick();
    rvalid_s = 1'b0;
    n_checks++; if (rvalid_m !== 1'b1) $display("FAIL sf_open got %b want 1", rvalid_m); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rvalid_m !== 1'b1 || rdata_m !== 32'h400 + i) $display("FAIL sf_drain[%0d] got v%b %h want v1 %h", i, rvalid_m, rdata_m, 32'h400 + i); else n_pass++;
      tick();
    end
    rready_m = 1'b0;
    exp_q = {};
    for (int i = 0; i < 8; i++) begin
      drive_beat(4'b0010, 32'h500 + i, 1'b0);
      exp_q.push_back(32'h500 + i);
      if (i == 7) begin
        #1;
        n_checks++; if (rvalid_m !== 1'b0) $display("FAIL sf_level7 got %b want 0", rvalid_m); else n_pass++;
      end
      tick();
    end
    n_checks++; if (level !== 4'd8 || rvalid_m !== 1'b1) $display("FAIL sf_full got level %0d v%b want 8 v1", level, rvalid_m); else n_pass++;
    rready_m = 1'b1;
    idx = 8;
    cyc = 0;
    while ((idx < 10 || exp_q.size() != 0) && cyc < 40) begin
      if (idx < 10) drive_beat(4'b0010, 32'h500 + idx, idx == 9);
      else rvalid_s = 1'b0;
      #1;
      n_checks++; if (rvalid_m !== 1'b1) $display("FAIL sf_flow[%0d] got v%b want v1", cyc, rvalid_m); else n_pass++;
      if (rvalid_m) begin
        n_checks++; if (rdata_m !== exp_q[0] || rlast_m !== (exp_q[0] == 32'h509)) $display("FAIL sf_long[%0d] got %h l%b want %h", cyc, rdata_m, rlast_m, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
      end
      if (rvalid_s && rready_s) begin
        exp_q.push_back(32'h500 + idx);
        idx++;
      end
      tick();
      cyc++;
    end
    rvalid_s = 1'b0;
    rready_m = 1'b0;
    n_checks++; if (cyc >= 40) $display("FAIL sf_timeout got %0d cycles want <40", cyc); else n_pass++;
    n_checks++; if (level !== 4'd0 || bursts !== 4'd0) $display("FAIL sf_end got level %0d bursts %0d want 0 0", level, bursts); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_burst4();
    test_fill();
`ifdef RDATA_BUF_STORE_FWD_EN
    test_store_fwd();
`else
    test_stream();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
